// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with hit-in-cycle lookup and a burst line-fill FSM.
// A miss stalls IF while the line is refilled one word at a time; returns arrive in order.
module icache_fill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] pc_addr,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic [1:0]  dbg_state_o
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 16 - IDX_W - OFF_W - 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]       miss_idx_q, miss_idx_d;
    logic                   poison_q, poison_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [15:0]            data_mem [NUM_LINES][LINE_WORDS];

    logic [TAG_W-1:0]       pc_tag;
    logic [IDX_W-1:0]       pc_idx;
    logic [OFF_W-1:0]       pc_off;
    logic                   lookup_en, hit, beat_in, last_beat;
    logic                   unused_pc_bit0;

    assign pc_tag         = pc_addr[15:OFF_W+IDX_W+1];
    assign pc_idx         = pc_addr[OFF_W+IDX_W:OFF_W+1];
    assign pc_off         = pc_addr[OFF_W:1];
    assign unused_pc_bit0 = pc_addr[0];

    // Lookup is gated by rst_n so stall and hit drop the instant reset asserts.
    assign lookup_en   = rst_n & fetch_req & (state_q == S_IDLE);
    assign hit         = lookup_en & valid_q[pc_idx] & (tag_mem[pc_idx] == pc_tag);
    assign beat_in     = mem_data_valid & (state_q != S_IDLE);
    assign last_beat   = beat_in & (beat_cnt_q == LAST_WORD);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        poison_d    = poison_q;
        valid_d     = valid_q;
        instr_valid = hit;
        instr_out   = hit ? data_mem[pc_idx][pc_off] : 16'h0000;
        fetch_stall = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (flush) valid_d = '0;
                if (lookup_en && !hit) begin
                    fetch_stall     = 1'b1;
                    state_d         = S_FILL;
                    miss_tag_d      = pc_tag;
                    miss_idx_d      = pc_idx;
                    issue_cnt_d     = '0;
                    beat_cnt_d      = '0;
                    poison_d        = 1'b0;
                    // The old contents of this line are about to be overwritten.
                    valid_d[pc_idx] = 1'b0;
                end
            end
            S_FILL, S_DRAIN: begin
                fetch_stall = 1'b1;
                if (state_q == S_FILL) begin
                    mem_req  = 1'b1;
                    mem_addr = {miss_tag_q, miss_idx_q, issue_cnt_q, 1'b0};
                    if (issue_cnt_q == LAST_WORD) state_d = S_DRAIN;
                    else issue_cnt_d = issue_cnt_q + OFF_W'(1);
                end
                if (flush) begin
                    valid_d  = '0;
                    poison_d = 1'b1;
                end
                if (beat_in && !last_beat) beat_cnt_d = beat_cnt_q + OFF_W'(1);
                if (last_beat) begin
                    state_d = S_IDLE;
                    if (!(poison_q || flush)) valid_d[miss_idx_q] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            poison_q    <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
            poison_q    <= poison_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data arrays need no reset: valid bits guard every read.
    always_ff @(posedge clk) begin
        if (beat_in) data_mem[miss_idx_q][beat_cnt_q] <= mem_data_in;
        if (last_beat) tag_mem[miss_idx_q] <= miss_tag_q;
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: pipelined latency-4 memory, cache-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_icache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, fetch_req, flush, mem_data_valid;
    logic [15:0] pc_addr, mem_data_in;
    logic [15:0] instr_out, mem_addr;
    logic        instr_valid, fetch_stall, mem_req;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    icache_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .pc_addr        (pc_addr),
        .flush          (flush),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .fetch_stall    (fetch_stall),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // ---------------- test memory: pipelined, latency 4, word[a] = a ^ A5A5 ----------------
    logic        pv [8] = '{default: 1'b0};
    logic [15:0] pa [8] = '{default: 16'h0000};

    always @(negedge clk) begin
        pv[cyc % 8] = mem_req;
        pa[cyc % 8] = mem_addr;
    end

    initial begin
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= 4 && pv[(cyc - 4) % 8]) begin
                mem_data_valid = 1'b1;
                mem_data_in    = pa[(cyc - 4) % 8] ^ 16'hA5A5;
            end else begin
                mem_data_valid = 1'b0;
                mem_data_in    = 16'h0000;
            end
        end
    end

    // ---------------- reference model: cache contents + fill transaction ----------------
    logic        m_valid [32];
    logic [6:0]  m_tag   [32];
    logic        m_busy, m_poison;
    logic [15:0] m_base;
    int          m_issued, m_beats;

    function automatic logic m_hit();
        return fetch_req && m_valid[pc_addr[8:4]] && (m_tag[pc_addr[8:4]] == pc_addr[15:9]);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            m_busy = 1'b0; m_poison = 1'b0; m_issued = 0; m_beats = 0; m_base = 16'h0000;
        end else if (!m_busy) begin
            logic h;
            h = m_hit();
            if (flush) for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            if (fetch_req && !h) begin
                m_busy   = 1'b1;
                m_base   = {pc_addr[15:4], 4'h0};
                m_issued = 0;
                m_beats  = 0;
                m_poison = 1'b0;
                m_valid[pc_addr[8:4]] = 1'b0;
            end
        end else begin
            if (m_issued < 8) m_issued++;
            if (flush) begin
                m_poison = 1'b1;
                for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            end
            if (mem_data_valid) begin
                m_beats++;
                if (m_beats == 8) begin
                    m_busy = 1'b0;
                    if (!m_poison) begin
                        m_valid[m_base[8:4]] = 1'b1;
                        m_tag[m_base[8:4]]   = m_base[15:9];
                    end
                end
            end
        end
    end

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        logic h;
        if (!rst_n) begin
            chk("m_rst_valid", instr_valid, 0);
            chk("m_rst_instr", instr_out, 0);
            chk("m_rst_stall", fetch_stall, 0);
            chk("m_rst_req", mem_req, 0);
            chk("m_rst_addr", mem_addr, 0);
        end else if (!m_busy) begin
            h = m_hit();
            chk("m_idle_valid", instr_valid, h);
            chk("m_idle_instr", instr_out, h ? ((pc_addr & 16'hFFFE) ^ 16'hA5A5) : 16'h0000);
            chk("m_idle_stall", fetch_stall, fetch_req && !h);
            chk("m_idle_req", mem_req, 0);
            chk("m_idle_addr", mem_addr, 0);
        end else begin
            chk("m_fill_valid", instr_valid, 0);
            chk("m_fill_instr", instr_out, 0);
            chk("m_fill_stall", fetch_stall, 1);
            chk("m_fill_req", mem_req, m_issued < 8);
            chk("m_fill_addr", mem_addr, (m_issued < 8) ? m_base + 16'(2 * m_issued) : 16'h0000);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at cycle 0 of a miss (inputs already driven); follows the fill to the hit cycle.
    task automatic run_fill(input string name, input logic [15:0] base);
        logic [15:0] exp_q [$];
        bit done = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(base + 16'(2 * k));
        @(negedge clk);
        chk({name, "_miss_stall"}, fetch_stall, 1);
        for (int k = 0; k < 30 && !done; k++) begin
            next();
            @(negedge clk);
            if (mem_req) begin
                if (exp_q.size() > 0) chk({name, "_addr"}, mem_addr, exp_q.pop_front());
                else chk({name, "_extra_req"}, mem_req, 0);
            end
            if (!fetch_stall) done = 1'b1;
        end
        chk({name, "_done"}, done, 1);
        chk({name, "_left_reqs"}, 16'(exp_q.size()), 0);
        chk({name, "_hit_valid"}, instr_valid, 1);
        chk({name, "_hit_instr"}, instr_out, (pc_addr & 16'hFFFE) ^ 16'hA5A5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc_addr = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (3) next();
        @(negedge clk);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_ivalid", instr_valid, 0);
        next();
        rst_n = 1'b1;
        next();

        // 1: cold miss at 0x0000, exact cycle timing
        fetch_req = 1'b1; pc_addr = 16'h0000;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("t1_c0_stall", fetch_stall, 1);
                chk("t1_c0_req", mem_req, 0);
            end else if (k <= 8) begin
                chk("t1_req", mem_req, 1);
                chk("t1_addr", mem_addr, 16'(2 * (k - 1)));
            end else if (k <= 12) begin
                chk("t1_drain_req", mem_req, 0);
                chk("t1_drain_stall", fetch_stall, 1);
            end else begin
                chk("t1_c13_valid", instr_valid, 1);
                chk("t1_c13_instr", instr_out, 16'hA5A5);
                chk("t1_c13_stall", fetch_stall, 0);
            end
            next();
        end

        // 2: sequential hits in the filled line
        for (int p = 2; p <= 14; p += 2) begin
            pc_addr = 16'(p);
            @(negedge clk);
            chk("t2_valid", instr_valid, 1);
            chk("t2_instr", instr_out, 16'(p) ^ 16'hA5A5);
            chk("t2_req", mem_req, 0);
            chk("t2_stall", fetch_stall, 0);
            next();
        end

        // 3: conflict on index 0
        pc_addr = 16'h0200;
        run_fill("t3_tag1", 16'h0200);
        chk("t3_instr_lit", instr_out, 16'hA7A5);
        next();
        pc_addr = 16'h0000;
        run_fill("t3_tag0", 16'h0000);

        // 4: flush pulse during DRAIN poisons the line; same pc misses again
        next();
        pc_addr = 16'h0100;
        for (int k = 0; k <= 12; k++) begin
            flush = (k == 10);
            @(negedge clk);
            if (k == 10) chk("t4_drain_req", mem_req, 0);
            next();
        end
        flush = 1'b0;
        run_fill("t4_refill", 16'h0100);
        chk("t4_instr_lit", instr_out, 16'hA4A5);

        // 5: reset asserted in FILL cycle 4; line 0 was flushed, so this misses
        next();
        pc_addr = 16'h0000;
        @(negedge clk);
        chk("t5_miss", fetch_stall, 1);
        repeat (4) next();
        @(negedge clk);
        chk("t5_pre_req", mem_req, 1);
        chk("t5_pre_addr", mem_addr, 16'h0006);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_req", mem_req, 0);
        chk("t5_async_stall", fetch_stall, 0);
        chk("t5_async_addr", mem_addr, 0);
        next();
        fetch_req = 1'b0;
        next();
        rst_n = 1'b1;
        repeat (8) next();
        fetch_req = 1'b1;
        run_fill("t5_after_rst", 16'h0000);

        // flush in IDLE: same-cycle hit still reported, then the line is gone
        next();
        flush = 1'b1;
        @(negedge clk);
        chk("tf_hit_valid", instr_valid, 1);
        chk("tf_hit_instr", instr_out, 16'hA5A5);
        next();
        flush = 1'b0;
        run_fill("tf_refetch", 16'h0000);

        // 6: no fetch at an uncached pc
        next();
        fetch_req = 1'b0;
        pc_addr   = 16'h1230;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t6_req", mem_req, 0);
            chk("t6_valid", instr_valid, 0);
            chk("t6_stall", fetch_stall, 0);
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
